// File: rtl/register_file_16x32.sv
// register_file_16x32: 2-read/1-write register file with saturating write counter.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module register_file_16x32 #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ld_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [7:0]        wr_count
);
  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  we;
  always_comb we = ld_en ? (NREGS'(1) << wr_addr) : '0;
  always_ff @(posedge clk)
    for (int i = 0; i < NREGS; i++)
      if (clr) regs[i] <= '0;
      else if (we[i]) regs[i] <= wr_data;
  always_ff @(posedge clk)
    if (clr) wr_count <= '0;
    else if (ld_en && wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
`ifdef REGFILE_BYPASS_EN
  logic fwd;
  always_comb begin
    fwd = ld_en && !clr;
    rd_data_a = (fwd && rd_addr_a == wr_addr) ? wr_data : regs[rd_addr_a];
    rd_data_b = (fwd && rd_addr_b == wr_addr) ? wr_data : regs[rd_addr_b];
  end
`else
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
  end
`endif
endmodule

// File: tb/tb_register_file_16x32.sv
// tb_register_file_16x32: directed self-checking bench for register_file_16x32.
module tb_register_file_16x32;
  logic        clk = 0;
  logic        clr, ld_en;
  logic [3:0]  wr_addr, rd_addr_a, rd_addr_b;
  logic [31:0] wr_data, rd_data_a, rd_data_b;
  logic [7:0]  wr_count;
  int n_cmp = 0, n_err = 0;

  register_file_16x32 dut (
    .clk(clk), .clr(clr), .ld_en(ld_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    ld_en = 1; wr_addr = a; wr_data = d;
    step();
    ld_en = 0;
  endtask

  initial begin
    logic [31:0] exp_a, exp_b;
    clr = 1; ld_en = 0; wr_addr = 0; wr_data = 0; rd_addr_a = 0; rd_addr_b = 15;
    step();
    clr = 0; #1;
    chk("rst_a", rd_data_a, 0);
    chk("rst_b", rd_data_b, 0);
    chk("rst_cnt", {24'd0, wr_count}, 0);

    wr(3, 32'h0000000A);
    rd_addr_a = 3; #1;
    chk("r3_pre_clr", rd_data_a, 32'h0000000A);
    chk("cnt_1", {24'd0, wr_count}, 1);
    clr = 1; step(); clr = 0;
    rd_addr_a = 3; rd_addr_b = 5; #1;
    chk("clr_r3", rd_data_a, 0);
    chk("clr_r5", rd_data_b, 0);
    chk("clr_cnt", {24'd0, wr_count}, 0);

    wr(7, 32'h0000000B);
    rd_addr_a = 7; rd_addr_b = 7; #1;
    chk("wr_r7_a", rd_data_a, 32'h0000000B);
    chk("wr_r7_b", rd_data_b, 32'h0000000B);
    chk("wr_cnt", {24'd0, wr_count}, 1);

    wr(2, 32'h0000000C);
    ld_en = 0; wr_addr = 2; wr_data = 32'hFFFFFFFF;
    repeat (3) step();
    rd_addr_a = 2; #1;
    chk("hold_r2", rd_data_a, 32'h0000000C);
    chk("hold_cnt", {24'd0, wr_count}, 2);

    wr(9, 32'h00000001);
    ld_en = 1; wr_addr = 9; wr_data = 32'h00000002; rd_addr_a = 9; rd_addr_b = 7; #1;
`ifdef REGFILE_BYPASS_EN
    chk("rdw_a", rd_data_a, 32'h00000002);
`else
    chk("rdw_a", rd_data_a, 32'h00000001);
`endif
    chk("rdw_b_other", rd_data_b, 32'h0000000B);
    step(); ld_en = 0; #1;
    chk("rdw_after", rd_data_a, 32'h00000002);
    chk("rdw_cnt", {24'd0, wr_count}, 4);

    clr = 1; #2;
    chk("clr_between", rd_data_a, 32'h00000002);
    clr = 0;
    step();
    chk("clr_glitch_r9", rd_data_a, 32'h00000002);
    chk("clr_glitch_cnt", {24'd0, wr_count}, 4);

    clr = 1; ld_en = 1; wr_addr = 1; wr_data = 32'h12345678;
    step();
    clr = 0; ld_en = 0; rd_addr_a = 1; rd_addr_b = 9; #1;
    chk("prio_r1", rd_data_a, 0);
    chk("prio_r9", rd_data_b, 0);
    chk("prio_cnt", {24'd0, wr_count}, 0);

    ld_en = 1; wr_addr = 4; wr_data = 32'h111; step();
    wr_data = 32'h222; step();
    ld_en = 0; rd_addr_a = 4; #1;
    chk("last_wins", rd_data_a, 32'h222);
    chk("last_cnt", {24'd0, wr_count}, 2);

    clr = 1; step(); clr = 0;
    for (int i = 0; i < 300; i++) begin
      ld_en = 1; wr_addr = 4'(i); wr_data = 32'hA0000000 + i;
      step();
      if (i == 253) chk("sat_254", {24'd0, wr_count}, 32'hFE);
      if (i == 254) chk("sat_255", {24'd0, wr_count}, 32'hFF);
    end
    ld_en = 0; #1;
    chk("sat_300", {24'd0, wr_count}, 32'hFF);
    for (int a = 0; a < 16; a++) begin
      rd_addr_a = 4'(a); rd_addr_b = 4'(15 - a); #1;
      exp_a = 32'hA0000000 + ((a < 12) ? 288 + a : 272 + a);
      exp_b = 32'hA0000000 + ((15 - a < 12) ? 288 + 15 - a : 272 + 15 - a);
      chk($sformatf("sat_reg_a%0d", a), rd_data_a, exp_a);
      chk($sformatf("sat_reg_b%0d", 15 - a), rd_data_b, exp_b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
